// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: debounces mode/increment buttons, edits a
// BCD hour/minute snapshot and issues a one-cycle load strobe to the time counter.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h2,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m2,
  output logic [3:0] set_h1,
  output logic [3:0] set_h2,
  output logic [3:0] set_m1,
  output logic [3:0] set_m2,
  output logic       load,
  output logic       set_active,
  output logic [1:0] sel_field,
  output logic       blink
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

  localparam int unsigned DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BCW-1:0] BL_LAST = BCW'(BLINK_CYCLES - 1);

  // Button conditioning; bit 0 = mode, bit 1 = inc.
  logic [1:0]     raw, sync1_q, sync2_q, deb_q, deb_d, deb_dly_q, press;
  logic [DCW-1:0] db_cnt_q [2];
  logic [DCW-1:0] db_cnt_d [2];
  logic           mode_p, inc_p;

  assign raw = {btn_inc, btn_mode};

  // NOTE: every variable gets a default before the branches, so no latch is inferred.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b]    = deb_q[b];
      db_cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) deb_d[b] = ~deb_q[b];
        else                        db_cnt_d[b] = db_cnt_q[b] + 1'b1;
      end
    end
  end

  assign press  = deb_q & ~deb_dly_q;
  assign mode_p = press[0];
  assign inc_p  = press[1];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= db_cnt_d[b];
    end
  end

  // BCD increments; out-of-range captures wrap straight to 00.
  function automatic logic [7:0] hr_inc(input logic [3:0] t, input logic [3:0] u);
    if (t > 4'd2 || (t == 4'd2 && u >= 4'd3)) return 8'h00;
    if (u >= 4'd9)                             return {t + 4'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
    if (t > 4'd5 || (t == 4'd5 && u >= 4'd9)) return 8'h00;
    if (u >= 4'd9)                             return {t + 4'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  state_t state_q, state_d;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Mode always wins over a same-cycle increment.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mode_p) state_d = SET_HR;
      SET_HR:  if (mode_p) state_d = SET_MIN;
      SET_MIN: if (mode_p) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    set_active = (state_q != RUN);
    unique case (state_q)
      SET_HR:  sel_field = 2'b01;
      SET_MIN: sel_field = 2'b10;
      default: sel_field = 2'b00;
    endcase
  end

  logic [7:0]     hr_q, hr_d, min_q, min_d;
  logic           load_q, load_d, blink_q, blink_d;
  logic [BCW-1:0] bl_cnt_q, bl_cnt_d;

  always_comb begin
    hr_d   = hr_q;
    min_d  = min_q;
    load_d = 1'b0;
    unique case (state_q)
      RUN: if (mode_p) begin
        hr_d  = {cur_h1, cur_h2};
        min_d = {cur_m1, cur_m2};
      end
      SET_HR:  if (!mode_p && inc_p) hr_d = hr_inc(hr_q[7:4], hr_q[3:0]);
      SET_MIN: begin
        if (mode_p)     load_d = 1'b1;
        else if (inc_p) min_d  = min_inc(min_q[7:4], min_q[3:0]);
      end
      default: ;
    endcase
  end

  // Blink restarts high on entry from RUN and free-runs through both set states.
  always_comb begin
    bl_cnt_d = '0;
    blink_d  = 1'b0;
    if (state_d == RUN) begin
      bl_cnt_d = '0;
      blink_d  = 1'b0;
    end else if (state_q == RUN) begin
      bl_cnt_d = '0;
      blink_d  = 1'b1;
    end else if (bl_cnt_q == BL_LAST) begin
      bl_cnt_d = '0;
      blink_d  = ~blink_q;
    end else begin
      bl_cnt_d = bl_cnt_q + 1'b1;
      blink_d  = blink_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hr_q     <= '0;
      min_q    <= '0;
      load_q   <= 1'b0;
      blink_q  <= 1'b0;
      bl_cnt_q <= '0;
    end else begin
      hr_q     <= hr_d;
      min_q    <= min_d;
      load_q   <= load_d;
      blink_q  <= blink_d;
      bl_cnt_q <= bl_cnt_d;
    end
  end

  assign set_h1 = hr_q[7:4];
  assign set_h2 = hr_q[3:0];
  assign set_m1 = min_q[7:4];
  assign set_m2 = min_q[3:0];
  assign load   = load_q;
  assign blink  = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: table-driven sessions, hand-written
// corner sequences and randomized sessions against a clock-arithmetic model.
module tb_time_set_ctrl;

  localparam int DEB   = 4;
  localparam int BLINK = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0;
  logic [3:0] cur_h1 = '0, cur_h2 = '0, cur_m1 = '0, cur_m2 = '0;
  logic [3:0] set_h1, set_h2, set_m1, set_m2;
  logic       load, set_active, blink;
  logic [1:0] sel_field;

  time_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLINK)) dut (
    .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h1(cur_h1), .cur_h2(cur_h2), .cur_m1(cur_m1), .cur_m2(cur_m2),
    .set_h1(set_h1), .set_h2(set_h2), .set_m1(set_m1), .set_m2(set_m2),
    .load(load), .set_active(set_active), .sel_field(sel_field), .blink(blink)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain clock arithmetic on whole hours/minutes.
  function automatic int ref_h(input int h);
    return (h >= 23) ? 0 : h + 1;
  endfunction
  function automatic int ref_m(input int m);
    return (m >= 59) ? 0 : m + 1;
  endfunction

  // Load and blink monitor.
  bit         mon_en = 0;
  int         load_cnt = 0;
  logic       prev_load = 1'b0, prev_act = 1'b0;
  int         k = 0;
  logic [3:0] ld_h1, ld_h2, ld_m1, ld_m2;

  always @(negedge clock) begin
    if (mon_en) begin
      if (load === 1'b1) begin
        load_cnt++;
        {ld_h1, ld_h2, ld_m1, ld_m2} = {set_h1, set_h2, set_m1, set_m2};
        check("load_one_cycle", prev_load, 1'b0);
      end
      prev_load = load;
      if (set_active === 1'b1) begin
        k = (prev_act === 1'b1) ? k + 1 : 0;
        check("blink_phase", blink, ((k / BLINK) % 2) == 0);
      end else begin
        check("blink_idle", blink, 1'b0);
      end
      prev_act = set_active;
    end
  end

  // Called at a negedge; returns at a negedge after the button has settled.
  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    repeat (7) @(negedge clock);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (7) @(negedge clock);
  endtask

  task automatic session(input int h1, h2, m1, m2, nh, nm, exp_h, exp_m, input string tag);
    int h, m, lc0;
    h   = h1 * 10 + h2;
    m   = m1 * 10 + m2;
    lc0 = load_cnt;
    {cur_h1, cur_h2, cur_m1, cur_m2} = {4'(h1), 4'(h2), 4'(m1), 4'(m2)};
    press(1'b1, 1'b0);
    check({tag, "_sel_hr"}, sel_field, 2'b01);
    check({tag, "_active"}, set_active, 1'b1);
    check({tag, "_capture"}, {set_h1, set_h2, set_m1, set_m2},
          {4'(h1), 4'(h2), 4'(m1), 4'(m2)});
    {cur_h1, cur_h2, cur_m1, cur_m2} = 16'($urandom);
    for (int j = 0; j < nh; j++) begin
      press(1'b0, 1'b1);
      h = ref_h(h);
      check({tag, "_hr_step"}, {set_h1, set_h2}, {4'(h / 10), 4'(h % 10)});
    end
    press(1'b1, 1'b0);
    check({tag, "_sel_min"}, sel_field, 2'b10);
    for (int j = 0; j < nm; j++) begin
      press(1'b0, 1'b1);
      m = ref_m(m);
      check({tag, "_min_step"}, {set_m1, set_m2}, {4'(m / 10), 4'(m % 10)});
    end
    press(1'b1, 1'b0);
    check({tag, "_sel_run"}, sel_field, 2'b00);
    check({tag, "_inactive"}, set_active, 1'b0);
    check({tag, "_load_count"}, load_cnt, lc0 + 1);
    check({tag, "_load_hr"}, {ld_h1, ld_h2}, {4'(exp_h / 10), 4'(exp_h % 10)});
    check({tag, "_load_min"}, {ld_m1, ld_m2}, {4'(exp_m / 10), 4'(exp_m % 10)});
  endtask

  typedef struct {
    int cur_h;
    int cur_m;
    int n_h;
    int n_m;
    int exp_h;
    int exp_m;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{12, 34, 12, 0,  0, 34};
    vecs[1] = '{ 9, 58,  0, 3,  9,  1};
    vecs[2] = '{27, 45,  1, 0,  0, 45};
    vecs[3] = '{23, 59,  1, 1,  0,  0};
    vecs[4] = '{19,  9,  1, 1, 20, 10};
    vecs[5] = '{ 5, 70,  0, 1,  5,  0};

    // Reset with buttons toggling.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      btn_mode = 1'($urandom);
      btn_inc  = 1'($urandom);
    end
    check("rst_set", {set_h1, set_h2, set_m1, set_m2}, 16'h0000);
    check("rst_load", load, 1'b0);
    check("rst_active", set_active, 1'b0);
    check("rst_sel", sel_field, 2'b00);
    check("rst_blink", blink, 1'b0);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (8) @(negedge clock);
    reset  = 1'b1;
    mon_en = 1;
    repeat (8) @(negedge clock);
    check("rst_release_active", set_active, 1'b0);
    check("rst_release_load_count", load_cnt, 0);

    // Table-driven sessions.
    foreach (vecs[v])
      session(vecs[v].cur_h / 10, vecs[v].cur_h % 10, vecs[v].cur_m / 10, vecs[v].cur_m % 10,
              vecs[v].n_h, vecs[v].n_m, vecs[v].exp_h, vecs[v].exp_m, $sformatf("vec%0d", v));

    // Press latency and no auto-repeat on a long hold.
    btn_mode = 1'b1;
    repeat (6) @(negedge clock);
    check("latency_early", set_active, 1'b0);
    @(negedge clock);
    check("latency_edge", set_active, 1'b1);
    repeat (40) @(negedge clock);
    check("hold_no_repeat", sel_field, 2'b01);
    btn_mode = 1'b0;
    repeat (7) @(negedge clock);
    check("release_no_pulse", sel_field, 2'b01);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("latency_exit", sel_field, 2'b00);

    // Debounce glitches in SET_MIN.
    {cur_h1, cur_h2, cur_m1, cur_m2} = 16'h0815;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    for (int g = 1; g <= 3; g++) begin
      btn_inc = 1'b1;
      repeat (g) @(negedge clock);
      btn_inc = 1'b0;
      repeat (8) @(negedge clock);
      check($sformatf("glitch%0d", g), {set_m1, set_m2}, 8'h15);
    end
    btn_inc = 1'b1;
    repeat (6) @(negedge clock);
    btn_inc = 1'b0;
    repeat (8) @(negedge clock);
    check("glitch6", {set_m1, set_m2}, 8'h16);
    press(1'b1, 1'b0);
    check("glitch_load", {ld_h1, ld_h2, ld_m1, ld_m2}, 16'h0816);

    // Simultaneous mode and inc in SET_HR.
    {cur_h1, cur_h2, cur_m1, cur_m2} = 16'h1520;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    check("simul_sel", sel_field, 2'b10);
    check("simul_hr", {set_h1, set_h2}, 8'h16);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("simul_load", {ld_h1, ld_h2, ld_m1, ld_m2}, 16'h1621);

    // Reset mid-set aborts without load.
    begin
      int lc0;
      lc0 = load_cnt;
      {cur_h1, cur_h2, cur_m1, cur_m2} = 16'h1111;
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      check("midset_min", {set_m1, set_m2}, 8'h13);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      check("midset_active", set_active, 1'b0);
      check("midset_blink", blink, 1'b0);
      check("midset_sel", sel_field, 2'b00);
      check("midset_set", {set_h1, set_h2, set_m1, set_m2}, 16'h0000);
      repeat (20) @(negedge clock);
      check("midset_no_load", load_cnt, lc0);
    end

    // Randomized sessions against the model.
    for (int r = 0; r < 20; r++) begin
      int h1, h2, m1, m2, nh, nm, eh, em;
      h1 = $urandom_range(0, 9);
      h2 = $urandom_range(0, 9);
      m1 = $urandom_range(0, 9);
      m2 = $urandom_range(0, 9);
      nh = $urandom_range(0, 26);
      nm = $urandom_range(0, 61);
      eh = h1 * 10 + h2;
      em = m1 * 10 + m2;
      for (int j = 0; j < nh; j++) eh = ref_h(eh);
      for (int j = 0; j < nm; j++) em = ref_m(em);
      session(h1, h2, m1, m2, nh, nm, eh, em, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
